// File: rtl/sprite_fifo_if.sv
// ============================================================================
// Module   : sprite_fifo_if
// Brief    : Fetcher/mixer bus for sprite_fifo (push group in, slot-0 pixel out)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface sprite_fifo_if;
  logic            valid_pixels_in;
  logic [7:0][1:0] pixels_in;
  logic            palette_in;
  logic            priority_in;
  logic            x_flip_in;
  logic            pop_in;
  logic            flush_in;
  logic            empty_out;
  logic [3:0]      count_out;
  logic            pixel_valid_out;
  logic [1:0]      pixel_out;
  logic            palette_out;
  logic            priority_out;

  modport slave (
    input  valid_pixels_in, pixels_in, palette_in, priority_in, x_flip_in,
    input  pop_in, flush_in,
    output empty_out, count_out, pixel_valid_out, pixel_out, palette_out,
    output priority_out
  );

  modport master (
    output valid_pixels_in, pixels_in, palette_in, priority_in, x_flip_in,
    output pop_in, flush_in,
    input  empty_out, count_out, pixel_valid_out, pixel_out, palette_out,
    input  priority_out
  );
endinterface

`default_nettype wire

// File: rtl/sprite_fifo.sv
// ============================================================================
// Module   : sprite_fifo
// Brief    : 8-slot sprite pixel FIFO with transparent-pixel merge on push.
//            Optional horizontal flip at push: define SPRITE_FIFO_XFLIP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sprite_fifo #(
  parameter int DEPTH = 8
) (
  input  wire logic    clk_in,
  input  wire logic    rst_n_in,
  input  wire logic    tclk_in,
  sprite_fifo_if.slave bus
);

  localparam logic [3:0] c_FULL = 4'(DEPTH);

  logic [1:0] r_colour [DEPTH];
  logic       r_pal    [DEPTH];
  logic       r_prio   [DEPTH];
  logic [3:0] r_count;

  logic       w_pop;
  logic       w_push;
  logic [3:0] w_cnt_pop;
  logic [3:0] w_count_nxt;

  logic [1:0] w_sh_col  [DEPTH];
  logic       w_sh_pal  [DEPTH];
  logic       w_sh_prio [DEPTH];
  logic [1:0] w_new_col [DEPTH];
  logic [1:0] w_col_nxt [DEPTH];
  logic       w_pal_nxt [DEPTH];
  logic       w_prio_nxt[DEPTH];

  assign w_pop     = tclk_in & bus.pop_in & (r_count != 4'd0);
  assign w_push    = tclk_in & bus.valid_pixels_in;
  assign w_cnt_pop = r_count - {3'b000, w_pop};

  always_comb begin
    w_count_nxt = w_cnt_pop;
    if (bus.flush_in)
      w_count_nxt = 4'd0;
    else if (w_push)
      w_count_nxt = c_FULL;
  end

`ifndef SPRITE_FIFO_XFLIP_EN
  logic w_unused_xflip;
  assign w_unused_xflip = bus.x_flip_in;
`endif

  genvar gi;
  for (gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic w_load;

    // Pop is applied first; the push then merges into the shifted contents.
    if (gi < DEPTH - 1) begin : g_mid
      assign w_sh_col[gi]  = w_pop ? r_colour[gi+1] : r_colour[gi];
      assign w_sh_pal[gi]  = w_pop ? r_pal[gi+1]    : r_pal[gi];
      assign w_sh_prio[gi] = w_pop ? r_prio[gi+1]   : r_prio[gi];
    end else begin : g_top
      assign w_sh_col[gi]  = w_pop ? 2'b00 : r_colour[gi];
      assign w_sh_pal[gi]  = w_pop ? 1'b0  : r_pal[gi];
      assign w_sh_prio[gi] = w_pop ? 1'b0  : r_prio[gi];
    end

`ifdef SPRITE_FIFO_XFLIP_EN
    assign w_new_col[gi] = bus.x_flip_in ? bus.pixels_in[DEPTH-1-gi] : bus.pixels_in[gi];
`else
    assign w_new_col[gi] = bus.pixels_in[gi];
`endif

    // Empty slots take the new pixel; occupied ones only lose a transparent pixel.
    assign w_load = w_push &&
                    ((4'(gi) >= w_cnt_pop) ||
                     ((w_sh_col[gi] == 2'b00) && (w_new_col[gi] != 2'b00)));

    always_comb begin
      w_col_nxt[gi]  = w_sh_col[gi];
      w_pal_nxt[gi]  = w_sh_pal[gi];
      w_prio_nxt[gi] = w_sh_prio[gi];
      if (bus.flush_in) begin
        w_col_nxt[gi]  = 2'b00;
        w_pal_nxt[gi]  = 1'b0;
        w_prio_nxt[gi] = 1'b0;
      end else if (w_load) begin
        w_col_nxt[gi]  = w_new_col[gi];
        w_pal_nxt[gi]  = bus.palette_in;
        w_prio_nxt[gi] = bus.priority_in;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_count <= 4'd0;
      for (int i = 0; i < DEPTH; i++) begin
        r_colour[i] <= 2'b00;
        r_pal[i]    <= 1'b0;
        r_prio[i]   <= 1'b0;
      end
    end else if (tclk_in) begin
      r_count <= w_count_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        r_colour[i] <= w_col_nxt[i];
        r_pal[i]    <= w_pal_nxt[i];
        r_prio[i]   <= w_prio_nxt[i];
      end
    end
  end

  assign bus.empty_out       = (r_count == 4'd0);
  assign bus.count_out       = r_count;
  assign bus.pixel_valid_out = (r_count != 4'd0);
  assign bus.pixel_out       = (r_count != 4'd0) ? r_colour[0] : 2'b00;
  assign bus.palette_out     = (r_count != 4'd0) ? r_pal[0]    : 1'b0;
  assign bus.priority_out    = (r_count != 4'd0) ? r_prio[0]   : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sprite_fifo.sv
// ============================================================================
// Module   : tb_sprite_fifo
// Brief    : Directed + randomized bench for sprite_fifo against a queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sprite_fifo;

  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  logic tclk_in  = 1'b0;

  sprite_fifo_if bus();

  sprite_fifo #(.DEPTH(8)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .tclk_in  (tclk_in),
    .bus      (bus)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [1:0] c;
    logic       pal;
    logic       prio;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = mq.size();
    chk({tag, "_count"}, 8'(bus.count_out), 8'(n));
    chk({tag, "_empty"}, 8'(bus.empty_out), 8'(n == 0));
    chk({tag, "_pvalid"}, 8'(bus.pixel_valid_out), 8'(n != 0));
    chk({tag, "_pixel"}, 8'(bus.pixel_out), (n != 0) ? 8'(mq[0].c) : 8'd0);
    chk({tag, "_pal"}, 8'(bus.palette_out), (n != 0) ? 8'(mq[0].pal) : 8'd0);
    chk({tag, "_prio"}, 8'(bus.priority_out), (n != 0) ? 8'(mq[0].prio) : 8'd0);
  endtask

  // Behavioural model: occupied slots are a queue; slot i is mq[i].
  task automatic model_step(input logic t, input logic v, input logic [7:0][1:0] pix,
                            input logic pal, input logic prio, input logic flip,
                            input logic pop, input logic flush);
    logic [1:0] nc;
    if (!t) return;
    if (flush) begin
      mq.delete();
      return;
    end
    if (pop && mq.size() > 0) void'(mq.pop_front());
    if (v) begin
      for (int i = 0; i < 8; i++) begin
`ifdef SPRITE_FIFO_XFLIP_EN
        nc = flip ? pix[7-i] : pix[i];
`else
        nc = pix[i];
`endif
        if (i >= mq.size()) mq.push_back('{c: nc, pal: pal, prio: prio});
        else if (mq[i].c == 2'd0 && nc != 2'd0) mq[i] = '{c: nc, pal: pal, prio: prio};
      end
    end
  endtask

  task automatic step(input logic t, input logic v, input logic [7:0][1:0] pix,
                      input logic pal, input logic prio, input logic flip,
                      input logic pop, input logic flush, input string tag);
    tclk_in             = t;
    bus.valid_pixels_in = v;
    bus.pixels_in       = pix;
    bus.palette_in      = pal;
    bus.priority_in     = prio;
    bus.x_flip_in       = flip;
    bus.pop_in          = pop;
    bus.flush_in        = flush;
    model_step(t, v, pix, pal, prio, flip, pop, flush);
    @(posedge clk_in);
    #1;
    check_all(tag);
  endtask

  task automatic do_pop(input string tag);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, tag);
  endtask

  task automatic async_reset(input string tag);
    rst_n_in = 1'b0;
    #2;
    mq.delete();
    check_all(tag);
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  logic [7:0][1:0] p_a, p_3, p_f, p_r;
  logic [1:0]      exp_col [8];
  logic            exp_pal [8];

  initial begin
    bus.valid_pixels_in = 1'b0;
    bus.pixels_in       = '0;
    bus.palette_in      = 1'b0;
    bus.priority_in     = 1'b0;
    bus.x_flip_in       = 1'b0;
    bus.pop_in          = 1'b0;
    bus.flush_in        = 1'b0;
    p_a = {2'd0, 2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd2, 2'd1};
    p_3 = {8{2'd3}};
    p_f = {2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};

    #12;
    check_all("reset");
    @(negedge clk_in);
    rst_n_in = 1'b1;

    step(1'b0, 1'b1, p_a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "gated_push");
    step(1'b1, 1'b1, p_a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "push_a");
    chk("r29_count", 8'(bus.count_out), 8'd8);
    chk("r29_pixel", 8'(bus.pixel_out), 8'd1);
    chk("r29_pal", 8'(bus.palette_out), 8'd1);
    chk("r29_empty", 8'(bus.empty_out), 8'd0);

    for (int k = 0; k < 3; k++) do_pop("r30_pop");
    step(1'b1, 1'b1, p_3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "r30_push");
    exp_col = '{2'd3, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    exp_pal = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    chk("r30_count", 8'(bus.count_out), 8'd8);
    for (int k = 0; k < 8; k++) begin
      chk("r30_slot_col", 8'(bus.pixel_out), 8'(exp_col[k]));
      chk("r30_slot_pal", 8'(bus.palette_out), 8'(exp_pal[k]));
      do_pop("r30_drain");
    end

    step(1'b1, 1'b1, p_a, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "r31_fill");
    step(1'b1, 1'b1, p_3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "r31_poppush");
    chk("r31_count", 8'(bus.count_out), 8'd8);
    chk("r31_pixel", 8'(bus.pixel_out), 8'd2);

    for (int k = 0; k < 9; k++) do_pop("r32_pop");
    chk("r32_count", 8'(bus.count_out), 8'd0);
    chk("r32_empty", 8'(bus.empty_out), 8'd1);
    chk("r32_pixel", 8'(bus.pixel_out), 8'd0);

    step(1'b1, 1'b1, p_a, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "r33_fill");
    step(1'b1, 1'b1, p_3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "r33_flush");
    chk("r33_count", 8'(bus.count_out), 8'd0);
    chk("r33_empty", 8'(bus.empty_out), 8'd1);
    step(1'b1, 1'b1, p_a, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "r33_refill");
    async_reset("r33_async");
    step(1'b1, 1'b1, p_3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "post_reset_push");
    chk("post_reset_pixel", 8'(bus.pixel_out), 8'd3);

    step(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "r34_clear");
    step(1'b1, 1'b1, p_f, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "r34_push");
`ifdef SPRITE_FIFO_XFLIP_EN
    chk("r34_first", 8'(bus.pixel_out), 8'd2);
    for (int k = 0; k < 7; k++) do_pop("r34_pop");
    chk("r34_last", 8'(bus.pixel_out), 8'd1);
`else
    chk("r34_first", 8'(bus.pixel_out), 8'd1);
    for (int k = 0; k < 7; k++) do_pop("r34_pop");
    chk("r34_last", 8'(bus.pixel_out), 8'd2);
`endif

    for (int n = 0; n < 600; n++) begin
      p_r = 16'($urandom());
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rand_async");
      end else begin
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, p_r,
             1'($urandom()), 1'($urandom()), 1'($urandom()),
             1'($urandom()), $urandom_range(0, 24) == 0, "rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sprite_fifo.md
SPRITE_FIFO -- requirements
Module: sprite_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning FIFO slots; only 8 is supported (one tile row).
REQ-002 SHALL have port clk_in, input, 1, system clock.
REQ-003 SHALL have port rst_n_in, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port tclk_in, input, 1, T-cycle enable; all state changes other than reset occur only on clk_in edges with tclk_in=1.
REQ-005 SHALL have port valid_pixels_in, input, 1, push request for one 8-pixel group from the sprite fetcher.
REQ-006 SHALL have port pixels_in, input, 8x2, pixel colour indices; element 0 is the leftmost pixel.
REQ-007 SHALL have port palette_in, input, 1, OBP0/OBP1 select for the pushed group.
REQ-008 SHALL have port priority_in, input, 1, BG-over-OBJ flag for the pushed group.
REQ-009 SHALL have port x_flip_in, input, 1, horizontal flip of the pushed group.
REQ-010 SHALL have port pop_in, input, 1, mixer consumes one pixel.
REQ-011 SHALL have port flush_in, input, 1, discard all contents (scanline end, mode change).
REQ-012 SHALL have port empty_out, output, 1, high when count is 0.
REQ-013 SHALL have port count_out, output, 4, occupied slots, 0..8.
REQ-014 SHALL have port pixel_valid_out, output, 1, slot 0 holds a pixel.
REQ-015 SHALL have ports pixel_out (2), palette_out (1), priority_out (1), outputs, slot-0 contents.

Function
REQ-016 Each slot SHALL store {colour[1:0], palette, priority}; count SHALL track occupied slots, which are always slots 0..count-1.
REQ-017 Outputs SHALL be combinational from slot 0 and count; pixel_out/palette_out/priority_out SHALL be 0 when count=0.
REQ-018 Pop (tclk_in & pop_in & count>0) SHALL shift slots down by one, clear slot DEPTH-1, and decrement count; pop on empty SHALL be ignored.
REQ-019 Push (tclk_in & valid_pixels_in) SHALL, per slot i, load the new pixel if i>=count, else replace the existing entry only when the existing colour is 0 and the new colour is nonzero; otherwise keep the existing entry.
REQ-020 After any push count SHALL be 8 (DEPTH).
REQ-021 Pop and push in the same T-cycle SHALL apply the pop first, then merge the push into the shifted contents; count SHALL become 8.
REQ-022 flush_in SHALL take priority over push and pop in the same T-cycle: all slots cleared, count=0.
REQ-023 Push data presented with tclk_in=0 SHALL be ignored; no internal latching of request lines.
REQ-024 empty_out SHALL feed the fetcher's empty input directly with zero-cycle latency from count.

Reset
REQ-025 On rst_n_in low, asynchronously: all slots 0, count 0; empty_out=1, count_out=0, pixel_valid_out=0, pixel_out=0, palette_out=0, priority_out=0.
REQ-026 Reset asserted mid-operation SHALL discard contents; the first tclk_in after release SHALL behave as on an empty FIFO.

Configuration
REQ-027 With macro SPRITE_FIFO_XFLIP_EN defined, x_flip_in=1 SHALL reverse pixel order at push (pixels_in[7] merges into slot 0).
REQ-028 Without SPRITE_FIFO_XFLIP_EN, x_flip_in SHALL be ignored and pixels_in[0] always merges into slot 0; the port remains present.

Verification
REQ-029 Reset, then push pixels {1,2,3,0,1,2,3,0}, palette=1 -> count_out=8, pixel_out=1, palette_out=1, empty_out=0.
REQ-030 Push {1,2,3,0,1,2,3,0}, pop 3 times, push {3,3,3,3,3,3,3,3} palette=0 -> slots {0->3,1,2,3,0->3,3,3,3} = {3,1,2,3,3,3,3,3}, count 8; slots 0 and 4 palette 0, slots 1-3 palette 1.
REQ-031 Fill, assert pop_in and valid_pixels_in in same T-cycle -> pop applied first, count_out stays 8, merge against shifted contents.
REQ-032 Pop 9 times from full -> count reaches 0 after 8, 9th pop ignored, empty_out=1, pixel_out=0.
REQ-033 Full FIFO, assert flush_in with valid_pixels_in and pop_in -> count_out=0, empty_out=1 next T-cycle; rst_n_in low mid-stream -> all outputs 0 immediately, without waiting for clk_in.
REQ-034 With SPRITE_FIFO_XFLIP_EN, push {1,0,0,0,0,0,0,2} x_flip=1 -> pixel_out=2, last pixel 1; without macro -> pixel_out=1.
